// File: rtl/digct_stim_checker.sv
// Purpose: BIST stimulus/checker for the DigCt 5-in/3-flop block. It sweeps all 32 input
//          vectors PASSES times, compares the registered DigCt outputs against the golden
//          functions, and reports the error count, the first failing vector and pass/fail.
// Latency: stim is registered. Each vector is compared 2 clks after it is driven. busy
//          stays high for 32*PASSES+2 clks, then done rises.
// Backpressure: none. start is sampled only in IDLE/DONE and is ignored while busy.
// Ports: clk, rst (sync, active-high) | start (run request) | stim[4:0] -> DigCt IN1..IN5
//        dut_out[2:0] <- DigCt OUT1..OUT3 | busy, done, pass status | err_cnt (saturating),
//        first_err_vec, first_err_bits (expected ^ actual at the first mismatch).
module digct_stim_checker #(
  parameter int PASSES = 1,
  parameter int ERR_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [4:0]       stim,
  input  logic [2:0]       dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [4:0]       first_err_vec,
  output logic [2:0]       first_err_bits
);

  typedef enum logic [1:0] {IDLE, DRIVE, FLUSH, DONE} state_t;

  localparam logic [3:0] LAST_PASS = 4'(PASSES - 1);

  state_t     state_q, state_d;
  logic [4:0] vec_cnt;
  logic [3:0] pass_cnt;
  logic       flush_cnt;
  logic       stim_vld;   // stim currently carries a driven vector
  logic       vld_q;      // compare stage holds a vector whose DigCt result is now on dut_out
  logic [2:0] exp_q;
  logic [4:0] vec_q;
  logic       launch;
  logic       last_vec;
  logic [2:0] diff;

  // Golden DigCt functions: {E3, E2, E1}
  function automatic logic [2:0] golden(input logic [4:0] v);
    golden = {v[2] | ~v[3] | v[4], ~(v[1] & v[2]), v[0] | v[1] | ~v[2]};
  endfunction

  assign launch   = ((state_q == IDLE) || (state_q == DONE)) && start;
  assign last_vec = (vec_cnt == 5'd31) && (pass_cnt == LAST_PASS);
  assign diff     = exp_q ^ dut_out;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start)     state_d = DRIVE;
      DRIVE:      if (last_vec)  state_d = FLUSH;
      FLUSH:      if (flush_cnt) state_d = DONE;
      default:                   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      vec_cnt        <= '0;
      pass_cnt       <= '0;
      flush_cnt      <= 1'b0;
      stim           <= '0;
      stim_vld       <= 1'b0;
      vld_q          <= 1'b0;
      exp_q          <= '0;
      vec_q          <= '0;
      err_cnt        <= '0;
      first_err_vec  <= '0;
      first_err_bits <= '0;
    end else begin
      state_q <= state_d;

      // Stimulus sequencing
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            vec_cnt   <= '0;
            pass_cnt  <= '0;
            flush_cnt <= 1'b0;
            stim      <= '0;
            stim_vld  <= 1'b1;
          end
        end
        DRIVE: begin
          if (last_vec) begin
            stim     <= '0;
            stim_vld <= 1'b0;
          end else begin
            vec_cnt <= vec_cnt + 5'd1;
            stim    <= vec_cnt + 5'd1;
            if (vec_cnt == 5'd31) pass_cnt <= pass_cnt + 4'd1;
          end
        end
        FLUSH: flush_cnt <= 1'b1;
        default: ;
      endcase

      // Compare stage 1: DigCt samples stim at this same edge, so its result is
      // on dut_out one clk later, when stage 2 looks at it.
      exp_q <= golden(stim);
      vec_q <= stim;
      vld_q <= stim_vld;

      // Compare stage 2. The pipe is always empty at launch, so clearing wins.
      if (launch) begin
        err_cnt        <= '0;
        first_err_vec  <= '0;
        first_err_bits <= '0;
      end else if (vld_q && (diff != 3'b000)) begin
        // err_cnt never returns to zero within a run, so zero marks the first miss
        if (err_cnt == '0) begin
          first_err_vec  <= vec_q;
          first_err_bits <= diff;
        end
        if (err_cnt != {ERR_W{1'b1}}) err_cnt <= err_cnt + ERR_W'(1);
      end
    end
  end

  assign busy = (state_q == DRIVE) || (state_q == FLUSH);
  assign done = (state_q == DONE);
  assign pass = done && (err_cnt == '0);

endmodule

// File: tb/tb_digct_stim_checker.sv
// Purpose: directed bench for digct_stim_checker with three instances (PASSES/ERR_W = 1/6,
//          1/4, 3/6), each facing a behavioural DigCt whose outputs can be faulted.
// Latency: the DigCt model registers its outputs one clk after stim.
// Backpressure: none. All stimulus is driven and all outputs sampled on the falling edge.
module tb_digct_stim_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] start = 3'b000;
  logic [2:0] busy, done, pass;
  logic [4:0] stim_w [3];
  logic [2:0] dout [3];
  logic [5:0] err [3];
  logic [3:0] err_b4;
  logic [4:0] fvec [3];
  logic [2:0] fbits [3];
  int         fault [3];
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  digct_stim_checker #(.PASSES(1), .ERR_W(6)) u_a (
    .clk(clk), .rst(rst), .start(start[0]), .stim(stim_w[0]), .dut_out(dout[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_cnt(err[0]),
    .first_err_vec(fvec[0]), .first_err_bits(fbits[0]));

  digct_stim_checker #(.PASSES(1), .ERR_W(4)) u_b (
    .clk(clk), .rst(rst), .start(start[1]), .stim(stim_w[1]), .dut_out(dout[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_cnt(err_b4),
    .first_err_vec(fvec[1]), .first_err_bits(fbits[1]));
  assign err[1] = {2'b00, err_b4};

  digct_stim_checker #(.PASSES(3), .ERR_W(6)) u_c (
    .clk(clk), .rst(rst), .start(start[2]), .stim(stim_w[2]), .dut_out(dout[2]),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_cnt(err[2]),
    .first_err_vec(fvec[2]), .first_err_bits(fbits[2]));

  // Behavioural DigCt: fault 1 = OUT2 stuck-at-1, fault 2 = OUT1 stuck-at-0
  function automatic logic [2:0] digct(input logic [4:0] v, input int f);
    logic [2:0] o;
    o = {v[2] | ~v[3] | v[4], ~(v[1] & v[2]), v[0] | v[1] | ~v[2]};
    if (f == 1) o[1] = 1'b1;
    if (f == 2) o[0] = 1'b0;
    return o;
  endfunction

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) dout[i] <= digct(stim_w[i], fault[i]);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Pulse start on instance id, follow the run to completion, return busy clks.
  task automatic run(input int id, input int np, input bit repulse, output int cyc);
    int k;
    int bad;
    @(negedge clk) start[id] = 1'b1;
    @(negedge clk) start[id] = 1'b0;
    chk("done_drop", done[id], 0);
    k = 0;
    bad = 0;
    while (busy[id] && k < 400) begin
      if (k < 32 * np) begin
        if (stim_w[id] != 5'(k % 32)) bad++;
      end else if (stim_w[id] != 5'd0) bad++;
      if (repulse) start[id] = (k == 40);
      k++;
      @(negedge clk);
    end
    start[id] = 1'b0;
    cyc = k;
    chk("stim_seq", bad, 0);
    chk("done_set", done[id], 1);
    chk("stim_idle", stim_w[id], 0);
  endtask

  initial begin
    int cyc;
    int w;
    fault[0] = 0;
    fault[1] = 2;
    fault[2] = 1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_pass", pass[0], 0);
    chk("rst_stim", stim_w[0], 0);
    chk("rst_err", err[0], 0);

    // Good DigCt, single pass
    run(0, 1, 1'b0, cyc);
    chk("good_busy", cyc, 34);
    chk("good_pass", pass[0], 1);
    chk("good_err", err[0], 0);
    chk("good_fvec", fvec[0], 0);
    chk("good_fbits", fbits[0], 0);

    // OUT2 stuck-at-1, started from DONE, then repeated for identical results
    fault[0] = 1;
    for (int r = 0; r < 2; r++) begin
      run(0, 1, 1'b0, cyc);
      chk("sa1_busy", cyc, 34);
      chk("sa1_err", err[0], 8);
      chk("sa1_fvec", fvec[0], 6);
      chk("sa1_fbits", fbits[0], 3'b010);
      chk("sa1_pass", pass[0], 0);
    end

    // OUT1 stuck-at-0 with a 4-bit counter: saturates at 15
    run(1, 1, 1'b0, cyc);
    chk("sat_busy", cyc, 34);
    chk("sat_err", err[1], 15);
    chk("sat_fvec", fvec[1], 0);
    chk("sat_fbits", fbits[1], 3'b001);
    chk("sat_pass", pass[1], 0);

    // Three passes, OUT2 stuck-at-1, start re-pulsed mid-run
    run(2, 3, 1'b1, cyc);
    chk("p3_busy", cyc, 98);
    chk("p3_err", err[2], 24);
    chk("p3_fvec", fvec[2], 6);
    chk("p3_fbits", fbits[2], 3'b010);

    // Reset mid-run while stim = 10
    fault[0] = 0;
    @(negedge clk) start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;
    w = 0;
    while (stim_w[0] != 5'd10 && w < 100) begin
      w++;
      @(negedge clk);
    end
    chk("wait_stim10", stim_w[0], 10);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("mrst_busy", busy[0], 0);
    chk("mrst_done", done[0], 0);
    chk("mrst_stim", stim_w[0], 0);
    chk("mrst_err", err[0], 0);
    run(0, 1, 1'b0, cyc);
    chk("post_busy", cyc, 34);
    chk("post_pass", pass[0], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
